// File: rtl/writeback.sv
// Writeback stage: turns the memory stage's result and d_cache word into the register-file write,
// with load extraction, misalignment detection, a one-deep forwarding history and a commit counter.
module writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_from_memory,
    input  logic [2:0]  funct3_from_memory,
    input  logic [4:0]  rd_from_memory,
    input  logic        write_reg_from_memory,
    input  logic        select_from_memory,
    input  logic [31:0] out_from_memory_dcache,
    output logic [4:0]  rd_to_regfile,
    output logic [31:0] data_to_regfile,
    output logic        write_to_regfile,
    output logic [4:0]  fwd1_rd,
    output logic [31:0] fwd1_data,
    output logic        fwd1_valid,
    output logic        load_misaligned,
    output logic [31:0] write_count
);

    logic [1:0]  off;
    logic [7:0]  lane_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        bad_load;
    logic        fault;
    logic        commit;
    logic [31:0] data_next;
    logic [31:0] write_count_reg;

    assign off = result_from_memory[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = out_from_memory_dcache[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane_byte[off];
    assign half_sel = off[1] ? out_from_memory_dcache[31:16] : out_from_memory_dcache[15:0];

    always_comb begin
        load_data = out_from_memory_dcache;
        bad_load  = 1'b0;
        case (funct3_from_memory)
            3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100: load_data = {24'd0, byte_sel};
            3'b001: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                bad_load  = off[0];
            end
            3'b101: begin
                load_data = {16'd0, half_sel};
                bad_load  = off[0];
            end
            3'b010: bad_load = (off != 2'b00);
            default: bad_load = 1'b1;
        endcase
    end

    // Faults only matter for loads that would actually write a register.
    assign fault     = select_from_memory & write_reg_from_memory & bad_load;
    assign commit    = write_reg_from_memory & (rd_from_memory != 5'd0) & ~fault;
    assign data_next = select_from_memory ? load_data : result_from_memory;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_to_regfile    <= 5'd0;
            data_to_regfile  <= 32'd0;
            write_to_regfile <= 1'b0;
            fwd1_rd          <= 5'd0;
            fwd1_data        <= 32'd0;
            fwd1_valid       <= 1'b0;
            load_misaligned  <= 1'b0;
            write_count_reg  <= 32'd0;
        end else begin
            rd_to_regfile    <= rd_from_memory;
            data_to_regfile  <= data_next;
            write_to_regfile <= commit;
            fwd1_rd          <= rd_to_regfile;
            fwd1_data        <= data_to_regfile;
            fwd1_valid       <= write_to_regfile;
            load_misaligned  <= fault;
            write_count_reg  <= write_count_reg + {31'd0, commit};
        end
    end

    assign write_count = write_count_reg;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: extension, faults, forwarding, counter wrap and async reset.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_from_memory;
    logic [2:0]  funct3_from_memory;
    logic [4:0]  rd_from_memory;
    logic        write_reg_from_memory;
    logic        select_from_memory;
    logic [31:0] out_from_memory_dcache;
    logic [4:0]  rd_to_regfile;
    logic [31:0] data_to_regfile;
    logic        write_to_regfile;
    logic [4:0]  fwd1_rd;
    logic [31:0] fwd1_data;
    logic        fwd1_valid;
    logic        load_misaligned;
    logic [31:0] write_count;

    int check_count = 0;
    int pass_count  = 0;

    writeback dut (
        .clk                    (clk),
        .rst                    (rst),
        .result_from_memory     (result_from_memory),
        .funct3_from_memory     (funct3_from_memory),
        .rd_from_memory         (rd_from_memory),
        .write_reg_from_memory  (write_reg_from_memory),
        .select_from_memory     (select_from_memory),
        .out_from_memory_dcache (out_from_memory_dcache),
        .rd_to_regfile          (rd_to_regfile),
        .data_to_regfile        (data_to_regfile),
        .write_to_regfile       (write_to_regfile),
        .fwd1_rd                (fwd1_rd),
        .fwd1_data              (fwd1_data),
        .fwd1_valid             (fwd1_valid),
        .load_misaligned        (load_misaligned),
        .write_count            (write_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs === exp) begin
            pass_count++;
            $display("ok   %-16s obs=%08h", tag, obs);
        end else begin
            $display("FAIL %-16s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // Apply one instruction and advance to just after the capturing edge.
    task automatic issue(input logic sel, input logic wr, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] res, input logic [31:0] q);
        select_from_memory     = sel;
        write_reg_from_memory  = wr;
        rd_from_memory         = rd;
        funct3_from_memory     = f3;
        result_from_memory     = res;
        out_from_memory_dcache = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rd"},    {27'd0, rd_to_regfile}, 32'd0);
        check({pfx, "_data"},  data_to_regfile, 32'd0);
        check({pfx, "_wr"},    {31'd0, write_to_regfile}, 32'd0);
        check({pfx, "_f1rd"},  {27'd0, fwd1_rd}, 32'd0);
        check({pfx, "_f1dat"}, fwd1_data, 32'd0);
        check({pfx, "_f1v"},   {31'd0, fwd1_valid}, 32'd0);
        check({pfx, "_mis"},   {31'd0, load_misaligned}, 32'd0);
        check({pfx, "_cnt"},   write_count, 32'd0);
    endtask

    localparam logic [31:0] Q = 32'h80FF_7F01;

    initial begin
        rst = 1'b0;
        select_from_memory = 0; write_reg_from_memory = 0; rd_from_memory = 0;
        funct3_from_memory = 0; result_from_memory = 0; out_from_memory_dcache = 0;
        #2;
        check_all_zero("rst");
        @(posedge clk); #1;
        rst = 1'b1;

        // ALU write
        issue(0, 1, 5'd5, 3'b000, 32'h1234_5678, 32'h0);
        check("alu_rd",   {27'd0, rd_to_regfile}, 32'd5);
        check("alu_data", data_to_regfile, 32'h1234_5678);
        check("alu_wr",   {31'd0, write_to_regfile}, 32'd1);
        check("alu_cnt",  write_count, 32'd1);

        // Load extraction
        issue(1, 1, 5'd6, 3'b000, 32'h0000_1001, Q);
        check("lb_off1",  data_to_regfile, 32'h0000_007F);
        issue(1, 1, 5'd6, 3'b000, 32'h0000_1003, Q);
        check("lb_off3",  data_to_regfile, 32'hFFFF_FF80);
        issue(1, 1, 5'd6, 3'b100, 32'h0000_1002, Q);
        check("lbu_off2", data_to_regfile, 32'h0000_00FF);
        issue(1, 1, 5'd6, 3'b001, 32'h0000_1002, Q);
        check("lh_off2",  data_to_regfile, 32'hFFFF_80FF);
        issue(1, 1, 5'd6, 3'b101, 32'h0000_1000, Q);
        check("lhu_off0", data_to_regfile, 32'h0000_7F01);
        issue(1, 1, 5'd6, 3'b010, 32'h0000_1000, Q);
        check("lw_off0",  data_to_regfile, Q);
        check("lw_wr",    {31'd0, write_to_regfile}, 32'd1);
        check("ld_cnt",   write_count, 32'd7);

        // Faults
        issue(1, 1, 5'd7, 3'b010, 32'h0000_0102, Q);
        check("lw_mis_wr",  {31'd0, write_to_regfile}, 32'd0);
        check("lw_mis",     {31'd0, load_misaligned}, 32'd1);
        check("lw_mis_cnt", write_count, 32'd7);
        issue(0, 0, 5'd0, 3'b000, 32'h0, 32'h0);
        check("mis_pulse",  {31'd0, load_misaligned}, 32'd0);
        issue(1, 1, 5'd7, 3'b001, 32'h0000_0101, Q);
        check("lh_mis_wr",  {31'd0, write_to_regfile}, 32'd0);
        check("lh_mis",     {31'd0, load_misaligned}, 32'd1);
        issue(1, 1, 5'd7, 3'b011, 32'h0000_0100, Q);
        check("f011_wr",    {31'd0, write_to_regfile}, 32'd0);
        check("f011_mis",   {31'd0, load_misaligned}, 32'd1);
        check("f011_cnt",   write_count, 32'd7);
        issue(0, 0, 5'd0, 3'b000, 32'h0, 32'h0);
        check("mis_clear",  {31'd0, load_misaligned}, 32'd0);

        // select=0 ignores funct3 and offset
        issue(0, 1, 5'd8, 3'b011, 32'h0000_0103, Q);
        check("alu_nofault_wr",  {31'd0, write_to_regfile}, 32'd1);
        check("alu_nofault_mis", {31'd0, load_misaligned}, 32'd0);
        check("alu_nofault_dat", data_to_regfile, 32'h0000_0103);
        check("alu_nofault_cnt", write_count, 32'd8);

        // rd = 0
        issue(0, 1, 5'd0, 3'b000, 32'hDEAD_BEEF, 32'h0);
        check("rd0_wr",  {31'd0, write_to_regfile}, 32'd0);
        check("rd0_cnt", write_count, 32'd8);

        // Forwarding
        issue(0, 1, 5'd3, 3'b000, 32'h0000_000A, 32'h0);
        issue(0, 1, 5'd3, 3'b000, 32'h0000_000B, 32'h0);
        check("fwd_data",  data_to_regfile, 32'h0000_000B);
        check("fwd1_data", fwd1_data, 32'h0000_000A);
        check("fwd1_rd",   {27'd0, fwd1_rd}, 32'd3);
        check("fwd1_v",    {31'd0, fwd1_valid}, 32'd1);
        check("fwd_cnt",   write_count, 32'd10);

        // Counter wrap via backdoor preload
        dut.write_count_reg = 32'hFFFF_FFFF;
        issue(0, 0, 5'd0, 3'b000, 32'h0, 32'h0);
        check("wrap_hold", write_count, 32'hFFFF_FFFF);
        check("bubble_f1v", {31'd0, fwd1_valid}, 32'd1);
        issue(0, 1, 5'd9, 3'b000, 32'h0000_0001, 32'h0);
        check("wrap_zero", write_count, 32'd0);

        // Asynchronous reset mid-stream
        issue(0, 1, 5'd10, 3'b000, 32'h0000_00CC, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("arst");
        @(posedge clk); #1;
        rst = 1'b1;
        issue(0, 1, 5'd7, 3'b000, 32'h0000_0055, 32'h0);
        check("post_rst_data", data_to_regfile, 32'h0000_0055);
        check("post_rst_wr",   {31'd0, write_to_regfile}, 32'd1);
        check("post_rst_f1v",  {31'd0, fwd1_valid}, 32'd0);
        check("post_rst_f1d",  fwd1_data, 32'd0);
        check("post_rst_cnt",  write_count, 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
